// File: rtl/sequenciador_movimentos.sv
// Sequences the servo operations of one cube face move: optional base pre-rotation,
// flips, close lid, base turn, open lid; with per-operation timeout and error hold.
module sequenciador_movimentos #(
   parameter int TIMEOUT_CICLOS = 50000000,
   parameter int LARG_TIMEOUT   = 26
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic [2:0] face,
   input  logic [1:0] giros,
   input  logic       limpa_erro,
   input  logic       pronto_servo,
   output logic       inicia_servo,
   output logic       move_servo_peteleco,
   output logic       move_servo_tampa,
   output logic       move_servo_base,
   output logic [1:0] posicao_base,
   output logic       pronto,
   output logic       ocupado,
   output logic       erro,
   output logic [3:0] db_estado
);

   typedef enum logic [3:0] {
      OCIOSO          = 4'd0,
      CARREGA         = 4'd1,
      EMITE_BASE_PRE  = 4'd2,
      ESPERA_BASE_PRE = 4'd3,
      EMITE_FLIP      = 4'd4,
      ESPERA_FLIP     = 4'd5,
      EMITE_FECHA     = 4'd6,
      ESPERA_FECHA    = 4'd7,
      EMITE_GIRO      = 4'd8,
      ESPERA_GIRO     = 4'd9,
      EMITE_ABRE      = 4'd10,
      ESPERA_ABRE     = 4'd11,
      FIM             = 4'd12,
      ERRO            = 4'd13
   } estado_t;

   localparam logic [LARG_TIMEOUT-1:0] TMO_MAX = LARG_TIMEOUT'(TIMEOUT_CICLOS - 1);

   estado_t                 estado, proximo;
   logic [2:0]              face_r;
   logic [1:0]              giros_r;
   logic [1:0]              pre_r, flips_r;
   logic [1:0]              pre_dec, flips_dec;
   logic                    face_valida;
   logic [1:0]              flip_cnt;
   logic [LARG_TIMEOUT-1:0] tmo_cnt;
   logic                    estourou;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      pre_dec     = 2'd0;
      flips_dec   = 2'd0;
      face_valida = 1'b1;
      case (face_r)
         3'd0: begin pre_dec = 2'd0; flips_dec = 2'd0; end
         3'd1: begin pre_dec = 2'd0; flips_dec = 2'd1; end
         3'd2: begin pre_dec = 2'd0; flips_dec = 2'd2; end
         3'd3: begin pre_dec = 2'd2; flips_dec = 2'd1; end
         3'd4: begin pre_dec = 2'd1; flips_dec = 2'd1; end
         3'd5: begin pre_dec = 2'd3; flips_dec = 2'd1; end
         default: face_valida = 1'b0;
      endcase
   end

   assign estourou = (tmo_cnt == TMO_MAX);

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) estado <= OCIOSO;
      else       estado <= proximo;
   end

   always_comb begin
      proximo = estado;
      case (estado)
         OCIOSO:  if (iniciar) proximo = CARREGA;
         CARREGA: begin
            if (!face_valida)          proximo = ERRO;
            else if (giros_r == 2'd0)  proximo = FIM;
            else if (pre_dec != 2'd0)  proximo = EMITE_BASE_PRE;
            else if (flips_dec != 2'd0) proximo = EMITE_FLIP;
            else                       proximo = EMITE_FECHA;
         end
         EMITE_BASE_PRE: proximo = ESPERA_BASE_PRE;
         EMITE_FLIP:     proximo = ESPERA_FLIP;
         EMITE_FECHA:    proximo = ESPERA_FECHA;
         EMITE_GIRO:     proximo = ESPERA_GIRO;
         EMITE_ABRE:     proximo = ESPERA_ABRE;
         ESPERA_BASE_PRE: begin
            if (pronto_servo)  proximo = (flips_r != 2'd0) ? EMITE_FLIP : EMITE_FECHA;
            else if (estourou) proximo = ERRO;
         end
         ESPERA_FLIP: begin
            if (pronto_servo)  proximo = (flip_cnt + 2'd1 == flips_r) ? EMITE_FECHA : EMITE_FLIP;
            else if (estourou) proximo = ERRO;
         end
         ESPERA_FECHA: begin
            if (pronto_servo)  proximo = EMITE_GIRO;
            else if (estourou) proximo = ERRO;
         end
         ESPERA_GIRO: begin
            if (pronto_servo)  proximo = EMITE_ABRE;
            else if (estourou) proximo = ERRO;
         end
         ESPERA_ABRE: begin
            if (pronto_servo)  proximo = FIM;
            else if (estourou) proximo = ERRO;
         end
         FIM:     proximo = OCIOSO;
         ERRO:    if (limpa_erro) proximo = OCIOSO;
         default: proximo = OCIOSO;
      endcase
   end

   // posicao_base is loaded on entry to the base EMITE states so it is valid with inicia_servo.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         face_r       <= 3'd0;
         giros_r      <= 2'd0;
         pre_r        <= 2'd0;
         flips_r      <= 2'd0;
         flip_cnt     <= 2'd0;
         tmo_cnt      <= '0;
         posicao_base <= 2'd0;
      end else begin
         if (estado == OCIOSO && iniciar) begin
            face_r  <= face;
            giros_r <= giros;
         end
         if (estado == CARREGA) begin
            pre_r    <= pre_dec;
            flips_r  <= flips_dec;
            flip_cnt <= 2'd0;
         end
         if (estado == ESPERA_FLIP && pronto_servo) flip_cnt <= flip_cnt + 2'd1;
         case (estado)
            EMITE_BASE_PRE, EMITE_FLIP, EMITE_FECHA, EMITE_GIRO, EMITE_ABRE:
               tmo_cnt <= '0;
            ESPERA_BASE_PRE, ESPERA_FLIP, ESPERA_FECHA, ESPERA_GIRO, ESPERA_ABRE:
               tmo_cnt <= tmo_cnt + 1'b1;
            default: ;
         endcase
         if (proximo == EMITE_BASE_PRE && estado != EMITE_BASE_PRE) posicao_base <= pre_dec;
         if (proximo == EMITE_GIRO && estado != EMITE_GIRO)         posicao_base <= giros_r;
      end
   end

   always_comb begin
      inicia_servo        = 1'b0;
      move_servo_peteleco = 1'b0;
      move_servo_tampa    = 1'b0;
      move_servo_base     = 1'b0;
      pronto              = 1'b0;
      ocupado             = 1'b1;
      erro                = 1'b0;
      db_estado           = estado;
      case (estado)
         OCIOSO:          ocupado = 1'b0;
         CARREGA:         ;
         EMITE_BASE_PRE:  begin inicia_servo = 1'b1; move_servo_base = 1'b1; end
         ESPERA_BASE_PRE: move_servo_base = 1'b1;
         EMITE_FLIP:      begin inicia_servo = 1'b1; move_servo_peteleco = 1'b1; end
         ESPERA_FLIP:     move_servo_peteleco = 1'b1;
         EMITE_FECHA:     begin inicia_servo = 1'b1; move_servo_tampa = 1'b1; end
         ESPERA_FECHA:    move_servo_tampa = 1'b1;
         EMITE_GIRO:      begin inicia_servo = 1'b1; move_servo_base = 1'b1; end
         ESPERA_GIRO:     move_servo_base = 1'b1;
         EMITE_ABRE:      begin inicia_servo = 1'b1; move_servo_tampa = 1'b1; end
         ESPERA_ABRE:     move_servo_tampa = 1'b1;
         FIM:             pronto = 1'b1;
         ERRO:            begin erro = 1'b1; ocupado = 1'b0; end
         default:         begin ocupado = 1'b0; db_estado = 4'd15; end
      endcase
   end

endmodule

// File: tb/tb_sequenciador_movimentos.sv
// Directed bench for sequenciador_movimentos: operation sequences, latency,
// timeout/error handling and asynchronous reset mid-operation.
module tb_sequenciador_movimentos;

   logic       clock = 1'b0;
   logic       reset;
   logic       iniciar = 1'b0;
   logic [2:0] face = 3'd0;
   logic [1:0] giros = 2'd0;
   logic       limpa_erro = 1'b0;
   logic       pronto_servo = 1'b0;
   logic       inicia_servo, move_servo_peteleco, move_servo_tampa, move_servo_base;
   logic [1:0] posicao_base;
   logic       pronto, ocupado, erro;
   logic [3:0] db_estado;

   int tests = 0;
   int fails = 0;

   // servo model and operation log
   bit         servo_on = 1'b1;
   int         servo_cnt = 0;
   logic [4:0] log_ops [8];
   int         n_ops = 0;
   int         n_pronto = 0;
   int         viol = 0;

   localparam logic [4:0] OP_PET   = 5'b100_00;
   localparam logic [4:0] OP_TAMPA = 5'b010_00;

   sequenciador_movimentos #(.TIMEOUT_CICLOS(20), .LARG_TIMEOUT(5)) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .face(face), .giros(giros),
      .limpa_erro(limpa_erro), .pronto_servo(pronto_servo), .inicia_servo(inicia_servo),
      .move_servo_peteleco(move_servo_peteleco), .move_servo_tampa(move_servo_tampa),
      .move_servo_base(move_servo_base), .posicao_base(posicao_base), .pronto(pronto),
      .ocupado(ocupado), .erro(erro), .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Servo answers pronto_servo three cycles after each inicia_servo pulse.
   always @(negedge clock) begin
      if (reset) begin
         servo_cnt = 0;
         if (servo_on) pronto_servo = 1'b0;
      end else begin
         if (servo_on) begin
            pronto_servo = 1'b0;
            if (servo_cnt != 0) begin
               servo_cnt--;
               if (servo_cnt == 0) pronto_servo = 1'b1;
            end
            if (inicia_servo) servo_cnt = 3;
         end
         if (inicia_servo && n_ops < 8) begin
            log_ops[n_ops] = move_servo_base ? {3'b001, posicao_base}
                                             : {move_servo_peteleco, move_servo_tampa, 3'b000};
            n_ops++;
         end
         if (pronto) n_pronto++;
         if (int'(move_servo_peteleco) + int'(move_servo_tampa) + int'(move_servo_base) > 1) viol++;
      end
   end

   task automatic limpa_log();
      n_ops = 0; n_pronto = 0; viol = 0;
   endtask

   task automatic pulso_iniciar(input logic [2:0] f, input logic [1:0] g);
      @(negedge clock);
      face = f; giros = g; iniciar = 1'b1;
      @(negedge clock);
      iniciar = 1'b0;
   endtask

   task automatic espera_estado(input logic [3:0] s, input string tag);
      int n = 0;
      while (db_estado !== s && n < 300) begin
         @(negedge clock);
         n++;
      end
      if (n >= 300) check(tag, db_estado, s);
   endtask

   task automatic roda_movimento(input string tag, input logic [2:0] f, input logic [1:0] g,
                                 input int n_exp, input logic [24:0] seq);
      limpa_log();
      pulso_iniciar(f, g);
      espera_estado(4'd12, {tag, "_timeout"});
      repeat (2) @(negedge clock);
      check({tag, "_nops"}, n_ops, n_exp);
      for (int i = 0; i < n_exp && i < 5; i++)
         check($sformatf("%s_op%0d", tag, i), log_ops[i], seq[24-5*i -: 5]);
      check({tag, "_npronto"}, n_pronto, 1);
      check({tag, "_onehot"}, viol, 0);
      check({tag, "_idle"}, db_estado, 4'd0);
   endtask

   initial begin
      int esp;
      reset = 1'b1;
      repeat (2) @(negedge clock);
      check("reset_outs", {inicia_servo, move_servo_peteleco, move_servo_tampa, move_servo_base,
                           posicao_base, pronto, ocupado, erro, db_estado}, 14'd0);
      reset = 1'b0;
      @(negedge clock);

      roda_movimento("d_cw", 3'd0, 2'd1, 3, {OP_TAMPA, 5'b001_01, OP_TAMPA, 10'd0});
      roda_movimento("u_180", 3'd2, 2'd2, 5, {OP_PET, OP_PET, OP_TAMPA, 5'b001_10, OP_TAMPA});
      roda_movimento("r_ccw", 3'd5, 2'd3, 5, {5'b001_11, OP_PET, OP_TAMPA, 5'b001_11, OP_TAMPA});
      roda_movimento("b_cw", 3'd3, 2'd1, 5, {5'b001_10, OP_PET, OP_TAMPA, 5'b001_01, OP_TAMPA});

      // zero-turn latency
      limpa_log();
      @(negedge clock);
      face = 3'd1; giros = 2'd0; iniciar = 1'b1;
      @(negedge clock);
      iniciar = 1'b0;
      check("lat_c1", {pronto, ocupado, db_estado}, {2'b01, 4'd1});
      @(negedge clock);
      check("lat_c2", {pronto, ocupado, db_estado}, {2'b11, 4'd12});
      @(negedge clock);
      check("lat_c3", {pronto, ocupado, db_estado}, {2'b00, 4'd0});
      check("lat_noops", n_ops, 0);

      // timeout with silent servo
      servo_on = 1'b0;
      pronto_servo = 1'b0;
      pulso_iniciar(3'd0, 2'd1);
      espera_estado(4'd7, "tmo_wait");
      esp = 1;
      while (esp < 100) begin
         @(negedge clock);
         if (db_estado == 4'd7) esp++;
         else break;
      end
      check("tmo_cycles", esp, 20);
      check("tmo_erro", {erro, ocupado, inicia_servo, move_servo_peteleco, move_servo_tampa,
                         move_servo_base, db_estado}, {6'b100000, 4'd13});
      pulso_iniciar(3'd0, 2'd1);
      check("erro_ignora_iniciar", db_estado, 4'd13);
      limpa_erro = 1'b1;
      @(negedge clock);
      limpa_erro = 1'b0;
      check("erro_limpa", db_estado, 4'd0);

      // pronto_servo on the last allowed cycle wins
      pulso_iniciar(3'd0, 2'd1);
      espera_estado(4'd7, "tmo2_wait");
      repeat (19) @(negedge clock);
      pronto_servo = 1'b1;
      @(negedge clock);
      pronto_servo = 1'b0;
      check("tmo_limite_ok", db_estado, 4'd8);
      @(negedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      servo_on = 1'b1;

      // invalid face
      limpa_log();
      pulso_iniciar(3'd6, 2'd1);
      @(negedge clock);
      check("face6_erro", db_estado, 4'd13);
      check("face6_noops", n_ops, 0);
      limpa_erro = 1'b1;
      @(negedge clock);
      limpa_erro = 1'b0;

      // asynchronous reset in ESPERA_FLIP
      pulso_iniciar(3'd5, 2'd1);
      espera_estado(4'd5, "rst_wait");
      #1 reset = 1'b1;
      #1;
      check("rst_async_outs", {inicia_servo, move_servo_peteleco, move_servo_tampa, move_servo_base,
                               posicao_base, pronto, ocupado, erro, db_estado}, 14'd0);
      @(negedge clock);
      reset = 1'b0;
      roda_movimento("pos_rst", 3'd0, 2'd1, 3, {OP_TAMPA, 5'b001_01, OP_TAMPA, 10'd0});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sequenciador_movimentos.md
SEQUENCIADOR_MOVIMENTOS -- requirements
Module: sequenciador_movimentos

Interface
REQ-001 SHALL have parameter TIMEOUT_CICLOS, default 50000000, max cycles waited for pronto_servo per servo operation.
REQ-002 SHALL have parameter LARG_TIMEOUT, default 26, width of the timeout counter.
REQ-003 clock  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 iniciar  input  1  start request; sampled only in OCIOSO.
REQ-006 face  input  3  face to turn: 0 D, 1 F, 2 U, 3 B, 4 L, 5 R; 6-7 invalid.
REQ-007 giros  input  2  quarter turns: 0 none, 1 cw 90, 2 180, 3 ccw 90.
REQ-008 limpa_erro  input  1  releases ERRO.
REQ-009 pronto_servo  input  1  one-cycle completion pulse from the servo manager.
REQ-010 inicia_servo  output  1  one-cycle start pulse to the servo manager.
REQ-011 move_servo_peteleco / move_servo_tampa / move_servo_base  output  1 each  one-hot operation select.
REQ-012 posicao_base  output  2  quarter-turn code for the base operation.
REQ-013 pronto  output  1  one-cycle move-complete pulse.
REQ-014 ocupado  output  1  high while a move is in progress.
REQ-015 erro  output  1  high in ERRO.
REQ-016 db_estado  output  4  state code.

Function
REQ-017 States, codes: OCIOSO 0, CARREGA 1, EMITE_BASE_PRE 2, ESPERA_BASE_PRE 3, EMITE_FLIP 4, ESPERA_FLIP 5, EMITE_FECHA 6, ESPERA_FECHA 7, EMITE_GIRO 8, ESPERA_GIRO 9, EMITE_ABRE 10, ESPERA_ABRE 11, FIM 12, ERRO 13; db_estado = code; illegal state -> db_estado 15, next state OCIOSO.
REQ-018 OCIOSO: iniciar=1 at an edge latches face, giros; next CARREGA.
REQ-019 CARREGA decodes face to (pre-base P, flips N): D(0,0) F(0,1) U(0,2) B(2,1) L(1,1) R(3,1), stored in registers.
REQ-020 CARREGA next: face 6/7 -> ERRO; else giros=0 -> FIM; else P!=0 -> EMITE_BASE_PRE; else N!=0 -> EMITE_FLIP; else EMITE_FECHA.
REQ-021 Every EMITE_x lasts one cycle: inicia_servo=1, selected move_servo_* = 1, timeout counter cleared; next ESPERA_x.
REQ-022 Every ESPERA_x: same move_servo_* held, inicia_servo=0, counter increments each cycle.
REQ-023 Operation select: BASE_PRE base (posicao_base=P); FLIP peteleco; FECHA tampa; GIRO base (posicao_base=giros); ABRE tampa; posicao_base registered, holds last value otherwise.
REQ-024 ESPERA_BASE_PRE on pronto_servo -> EMITE_FLIP if N!=0, else EMITE_FECHA.
REQ-025 ESPERA_FLIP on pronto_servo: flip counter +1; if count=N -> EMITE_FECHA, else EMITE_FLIP.
REQ-026 ESPERA_FECHA -> EMITE_GIRO, ESPERA_GIRO -> EMITE_ABRE, ESPERA_ABRE -> FIM, each on pronto_servo.
REQ-027 In any ESPERA_x, counter reaching TIMEOUT_CICLOS-1 with pronto_servo=0 -> ERRO; pronto_servo in that same cycle wins (normal transition).
REQ-028 pronto_servo outside ESPERA states SHALL be ignored.
REQ-029 FIM: pronto=1 for one cycle; next OCIOSO; iniciar during FIM ignored.
REQ-030 ERRO: erro=1, all move_servo_* and inicia_servo 0; limpa_erro=1 -> OCIOSO; iniciar ignored.
REQ-031 ocupado=1 in all states except OCIOSO and ERRO.
REQ-032 Exactly one move_servo_* high in EMITE/ESPERA states, none elsewhere.
REQ-033 Latency giros=0, valid face: iniciar sampled at edge k -> pronto high in cycle after edge k+1; no inicia_servo.

Reset
REQ-034 reset=1 SHALL immediately force OCIOSO and all outputs 0 (db_estado 0, posicao_base 0), clear latched face/giros, P, N, flip and timeout counters, regardless of state, including mid-operation.

Verification
REQ-035 face=0, giros=1, servo model pronto 3 cycles after each inicia -> 3 inicia pulses: tampa, base (posicao_base=1), tampa; one pronto pulse.
REQ-036 face=2, giros=2 -> 5 operations: peteleco, peteleco, tampa, base (posicao_base=2), tampa; pronto once.
REQ-037 face=5, giros=3 -> base (posicao_base=3), peteleco, tampa, base (posicao_base=3), tampa.
REQ-038 face=1, giros=0 -> pronto 2 cycles after iniciar edge, inicia_servo never high, ocupado high for 2 cycles.
REQ-039 TIMEOUT_CICLOS=20, servo model silent -> ERRO after 20 ESPERA cycles, erro=1, move_* 0; limpa_erro -> OCIOSO; pronto_servo on cycle 20 instead -> normal progress.
REQ-040 face=6 -> ERRO with no servo operation; reset asserted in ESPERA_FLIP -> all outputs 0 immediately, next iniciar starts cleanly.
